// File: rtl/rv_pkg.sv
// Shared RV32IM decode constants and the one-hot ALU select bundle used
// by the ID/EX stage and the ALU's caller.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef struct packed {
        logic add;
        logic sub;
        logic mul;
        logic mulh;
        logic mulhsu;
        logic mulhu;
        logic and_op;
        logic or_op;
        logic slt;
        logic sltu;
    } alu_sel_t;

    localparam alu_sel_t ALU_SEL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode bus between the ID/EX stage (master, supplies instruction fields)
// and the ALU decoder (slave, returns selects, operand-b source, illegal flag).
interface id_ex_stage_if;
    import rv_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_sel_t   sel;
    logic       use_imm;
    logic       illegal;

    modport master (
        output opcode, funct3, funct7,
        input  sel, use_imm, illegal
    );

    modport slave (
        input  opcode, funct3, funct7,
        output sel, use_imm, illegal
    );

endinterface

// File: rtl/id_ex_stage_alu_decode.sv
// Purely combinational RV32IM ALU decoder: opcode/funct3/funct7 to one-hot
// select, immediate operand source, and an illegal flag for anything else.
module alu_decode
    import rv_pkg::*;
(
    id_ex_stage_if.slave dec
);

    alu_sel_t sel;
    logic     use_imm;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        sel     = ALU_SEL_NONE;
        use_imm = 1'b0;
        case (dec.opcode)
            OPC_OP: begin
                case (dec.funct7)
                    F7_BASE: begin
                        case (dec.funct3)
                            F3_ADD:  sel.add    = 1'b1;
                            F3_AND:  sel.and_op = 1'b1;
                            F3_OR:   sel.or_op  = 1'b1;
                            F3_SLT:  sel.slt    = 1'b1;
                            F3_SLTU: sel.sltu   = 1'b1;
                            default: sel        = ALU_SEL_NONE;
                        endcase
                    end
                    F7_ALT: begin
                        if (dec.funct3 == F3_ADD) begin
                            sel.sub = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        case (dec.funct3)
                            F3_MUL:    sel.mul    = 1'b1;
                            F3_MULH:   sel.mulh   = 1'b1;
                            F3_MULHSU: sel.mulhsu = 1'b1;
                            F3_MULHU:  sel.mulhu  = 1'b1;
                            default:   sel        = ALU_SEL_NONE;
                        endcase
                    end
                    default: sel = ALU_SEL_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                case (dec.funct3)
                    F3_ADD:  sel.add    = 1'b1;
                    F3_SLT:  sel.slt    = 1'b1;
                    F3_SLTU: sel.sltu   = 1'b1;
                    F3_OR:   sel.or_op  = 1'b1;
                    F3_AND:  sel.and_op = 1'b1;
                    default: sel        = ALU_SEL_NONE;
                endcase
                use_imm = (sel != ALU_SEL_NONE);
            end
            OPC_LOAD, OPC_STORE: begin
                // Address generation: base register plus immediate.
                sel.add = 1'b1;
                use_imm = 1'b1;
            end
            default: sel = ALU_SEL_NONE;
        endcase
    end

    assign dec.sel     = sel;
    assign dec.use_imm = use_imm;
    assign dec.illegal = (sel == ALU_SEL_NONE);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded RV32IM fields with stall/flush,
// and resolves EX operands through MEM/WB forwarding.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic [6:0]            id_funct7,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [WIDTH-1:0]      id_rs1_data,
    input  logic [WIDTH-1:0]      id_rs2_data,
    input  logic [WIDTH-1:0]      id_imm,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_fwd_valid,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [WIDTH-1:0]      mem_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [WIDTH-1:0]      wb_fwd_data,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_illegal,
    output logic [WIDTH-1:0]      operand_a,
    output logic [WIDTH-1:0]      operand_b,
    output logic                  alu_sel_add,
    output logic                  alu_sel_sub,
    output logic                  alu_sel_mul,
    output logic                  alu_sel_mulh,
    output logic                  alu_sel_mulhsu,
    output logic                  alu_sel_mulhu,
    output logic                  alu_sel_and,
    output logic                  alu_sel_or,
    output logic                  alu_sel_slt,
    output logic                  alu_sel_sltu
);

    id_ex_stage_if dec_if ();

    assign dec_if.opcode = id_opcode;
    assign dec_if.funct3 = id_funct3;
    assign dec_if.funct7 = id_funct7;

    alu_decode u_alu_decode (
        .dec (dec_if)
    );

    logic                  valid_q,    valid_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
    logic [WIDTH-1:0]      rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]      rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0]      imm_q,      imm_d;
    logic                  use_imm_q,  use_imm_d;
    logic                  illegal_q,  illegal_d;
    alu_sel_t              sel_q,      sel_d;

    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        illegal_d  = illegal_q;
        sel_d      = sel_q;
        if (flush) begin
            // Bubble: operand fields are don't-care once valid drops.
            valid_d   = 1'b0;
            sel_d     = ALU_SEL_NONE;
            illegal_d = 1'b0;
            use_imm_d = 1'b0;
        end else if (!stall) begin
            valid_d    = id_valid;
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            sel_d      = id_valid ? dec_if.sel : ALU_SEL_NONE;
            illegal_d  = id_valid & dec_if.illegal;
            use_imm_d  = id_valid & dec_if.use_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            illegal_q  <= 1'b0;
            sel_q      <= ALU_SEL_NONE;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            illegal_q  <= illegal_d;
            sel_q      <= sel_d;
        end
    end

    // x0 is hard-wired zero, so it never takes a forwarded value; MEM is younger than WB.
    function automatic logic [WIDTH-1:0] fwd_operand(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [WIDTH-1:0]      reg_data,
        input logic                  mem_v,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [WIDTH-1:0]      mem_data,
        input logic                  wb_v,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [WIDTH-1:0]      wb_data
    );
        if (rs == '0)                 return reg_data;
        if (mem_v && (mem_rd == rs))  return mem_data;
        if (wb_v && (wb_rd == rs))    return wb_data;
        return reg_data;
    endfunction

    assign operand_a = fwd_operand(rs1_q, rs1_data_q,
                                   mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                   wb_fwd_valid, wb_fwd_rd, wb_fwd_data);

    assign operand_b = use_imm_q ? imm_q :
                       fwd_operand(rs2_q, rs2_data_q,
                                   mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                   wb_fwd_valid, wb_fwd_rd, wb_fwd_data);

    assign ex_valid       = valid_q;
    assign ex_rd          = rd_q;
    assign ex_illegal     = illegal_q;
    assign alu_sel_add    = sel_q.add;
    assign alu_sel_sub    = sel_q.sub;
    assign alu_sel_mul    = sel_q.mul;
    assign alu_sel_mulh   = sel_q.mulh;
    assign alu_sel_mulhsu = sel_q.mulhsu;
    assign alu_sel_mulhu  = sel_q.mulhu;
    assign alu_sel_and    = sel_q.and_op;
    assign alu_sel_or     = sel_q.or_op;
    assign alu_sel_slt    = sel_q.slt;
    assign alu_sel_sltu   = sel_q.sltu;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases plus random traffic,
// with expected EX contents modelled from the instruction-level rules.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        stall, flush;
    logic        mem_fwd_valid, wb_fwd_valid;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_illegal;
    logic [4:0]  ex_rd;
    logic [31:0] operand_a, operand_b;
    logic        s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and, s_or, s_slt, s_sltu;
    logic [9:0]  dut_sel;

    id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .stall(stall), .flush(flush),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_sel_add(s_add), .alu_sel_sub(s_sub), .alu_sel_mul(s_mul), .alu_sel_mulh(s_mulh),
        .alu_sel_mulhsu(s_mulhsu), .alu_sel_mulhu(s_mulhu), .alu_sel_and(s_and), .alu_sel_or(s_or),
        .alu_sel_slt(s_slt), .alu_sel_sltu(s_sltu)
    );

    assign dut_sel = {s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and, s_or, s_slt, s_sltu};

    always #5 clk = ~clk;

    // Bit positions in dut_sel.
    localparam int OP_ADD = 9, OP_SUB = 8, OP_MUL = 7, OP_MULH = 6, OP_MULHSU = 5;
    localparam int OP_MULHU = 4, OP_AND = 3, OP_OR = 2, OP_SLT = 1, OP_SLTU = 0;

    typedef struct {
        logic        valid;
        logic        illegal;
        logic        use_imm;
        logic [9:0]  sel;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, imm;
    } ex_t;

    ex_t  model;
    ex_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction table: returns the ALU operation index, -1 if not ALU-decodable.
    function automatic int ref_op(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, output logic imm);
        imm = 1'b0;
        if (opc == 7'b0110011) begin
            if (f7 == 7'b0000000) begin
                case (f3)
                    3'd0: return OP_ADD;
                    3'd7: return OP_AND;
                    3'd6: return OP_OR;
                    3'd2: return OP_SLT;
                    3'd3: return OP_SLTU;
                    default: return -1;
                endcase
            end
            if (f7 == 7'b0100000 && f3 == 3'd0) return OP_SUB;
            if (f7 == 7'b0000001) begin
                case (f3)
                    3'd0: return OP_MUL;
                    3'd1: return OP_MULH;
                    3'd2: return OP_MULHSU;
                    3'd3: return OP_MULHU;
                    default: return -1;
                endcase
            end
            return -1;
        end
        if (opc == 7'b0010011) begin
            imm = 1'b1;
            case (f3)
                3'd0: return OP_ADD;
                3'd2: return OP_SLT;
                3'd3: return OP_SLTU;
                3'd6: return OP_OR;
                3'd7: return OP_AND;
                default: return -1;
            endcase
        end
        if (opc == 7'b0000011 || opc == 7'b0100011) begin
            imm = 1'b1;
            return OP_ADD;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (rs == 5'd0) return regval;
        if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
        return regval;
    endfunction

    task automatic model_reset();
        model = '{valid: 1'b0, illegal: 1'b0, use_imm: 1'b0, sel: '0,
                  rd: '0, rs1: '0, rs2: '0, a: '0, b: '0, imm: '0};
    endtask

    task automatic set_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm);
        id_valid = v; id_opcode = opc; id_funct3 = f3; id_funct7 = f7;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic set_fwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        mem_fwd_valid = mv; mem_fwd_rd = mrd; mem_fwd_data = md;
        wb_fwd_valid  = wv; wb_fwd_rd  = wrd; wb_fwd_data  = wd;
    endtask

    // One clock: apply the stage rules to the model with the pre-edge inputs.
    task automatic step();
        int   op;
        logic imm_src;
        @(posedge clk);
        if (flush) begin
            model.valid   = 1'b0;
            model.sel     = '0;
            model.illegal = 1'b0;
            model.use_imm = 1'b0;
        end else if (!stall) begin
            model.valid = id_valid;
            model.rd    = id_rd;
            model.rs1   = id_rs1;
            model.rs2   = id_rs2;
            model.a     = id_rs1_data;
            model.b     = id_rs2_data;
            model.imm   = id_imm;
            op = ref_op(id_opcode, id_funct3, id_funct7, imm_src);
            model.sel     = (id_valid && op >= 0) ? (10'b1 << op) : 10'b0;
            model.illegal = id_valid && (op < 0);
            model.use_imm = id_valid && (op >= 0) && imm_src;
        end
        sb_q.push_back(model);
        #1;
    endtask

    // Monitor: compares the DUT each cycle against the oldest expected EX entry.
    initial begin
        ex_t e;
        while (!done) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
                check("ex_illegal", {31'b0, ex_illegal}, {31'b0, e.illegal});
                check("alu_sel", {22'b0, dut_sel}, {22'b0, e.sel});
                check("sel_onehot0", {31'b0, $onehot0(dut_sel)}, 32'd1);
                if (e.valid) begin
                    check("ex_rd", {27'b0, ex_rd}, {27'b0, e.rd});
                    if (!e.illegal) begin
                        check("operand_a", operand_a, exp_fwd(e.rs1, e.a));
                        check("operand_b", operand_b, e.use_imm ? e.imm : exp_fwd(e.rs2, e.b));
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] opc;
        logic [6:0] f7;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_ex_illegal", {31'b0, ex_illegal}, 32'd0);
        check("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        check("rst_sel", {22'b0, dut_sel}, 32'd0);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_operand_b", operand_b, 32'd0);
        #2 rst_n = 1'b1;

        // OP add, then OP-IMM slt whose rs2 collides with MEM forwarding.
        set_id(1'b1, 7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        step();
        set_fwd(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, '0, '0);
        set_id(1'b1, 7'b0010011, 3'd2, 7'h00, 5'd1, 5'd4, 5'd6, 32'd9, 32'd11, 32'hFFFF_FFFF);
        step();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

        // mulhsu, then div (illegal).
        set_id(1'b1, 7'b0110011, 3'd2, 7'h01, 5'd7, 5'd8, 5'd9, 32'h10, 32'h20, 32'd0);
        step();
        set_id(1'b1, 7'b0110011, 3'd4, 7'h01, 5'd7, 5'd8, 5'd9, 32'h10, 32'h20, 32'd0);
        step();

        // MEM beats WB; x0 never forwarded.
        set_id(1'b1, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd5, 5'd10, 32'h33, 32'h55, 32'd0);
        step();
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_id(1'b1, 7'b0110011, 3'd7, 7'h00, 5'd0, 5'd5, 5'd11, 32'h44, 32'h66, 32'd0);
        step();
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        step();

        // Stall for three cycles while WB data tracks 1, 2, 3; then release.
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        set_id(1'b1, 7'b0110011, 3'd6, 7'h00, 5'd5, 5'd6, 5'd12, 32'h11, 32'h22, 32'd0);
        step();
        stall = 1'b1;
        set_id(1'b1, 7'b0000011, 3'd2, 7'h00, 5'd13, 5'd14, 5'd15, 32'h100, 32'h200, 32'h40);
        for (int k = 1; k <= 3; k++) begin
            set_fwd(1'b0, '0, '0, 1'b1, 5'd5, k);
            step();
        end
        stall = 1'b0;
        step();

        // Stall and flush together with a valid ID instruction.
        stall = 1'b1;
        flush = 1'b1;
        set_id(1'b1, 7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0);
        step();
        flush = 1'b0;
        step();

        // Reset asserted mid-stall clears immediately; first edge after release captures.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("midrst_sel", {22'b0, dut_sel}, 32'd0);
        check("midrst_ex_rd", {27'b0, ex_rd}, 32'd0);
        model_reset();
        stall = 1'b0;
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        set_id(1'b1, 7'b0100011, 3'd2, 7'h00, 5'd2, 5'd3, 5'd0, 32'h1000, 32'h5, 32'h8);
        #1 rst_n = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    opc = 7'b0110011;
                2:       opc = 7'b0010011;
                3:       opc = 7'b0000011;
                4:       opc = 7'b0100011;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            set_id($urandom_range(0, 9) < 8, opc, 3'($urandom), f7,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                   $urandom, $urandom, $urandom);
            set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        stall = 1'b0;
        flush = 1'b0;

        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
